pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000: the PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h00004180: the redirect target used when exc is asserted.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  hazard-unit hold; while high, no new fetch is issued and the held fetch is kept.
REQ-006 exc  input  1  exception redirect to EXC_VECTOR.
REQ-007 jump  input  1  unconditional redirect to jump_target.
REQ-008 jump_target  input  32  jump destination.
REQ-009 branch  input  2  branch type: 01 = beq, 10 = bne, 00/11 = none.
REQ-010 alu_zero  input  1  branch-compare result (1 = operands equal).
REQ-011 branch_target  input  32  branch destination.
REQ-012 imem_req  output  1  instruction-memory request.
REQ-013 imem_addr  output  32  request address, word-aligned.
REQ-014 imem_ack  input  1  single-cycle completion of the outstanding request.
REQ-015 fetch_valid  output  1  IF/ID holds a valid fetched instruction.
REQ-016 fetch_pc  output  32  PC of the instruction marked by fetch_valid.
REQ-017 flush_ifid  output  1  one-cycle flush pulse to IF/ID.
REQ-018 pc_cur  output  32  next PC to fetch.

Function
REQ-019 Redirect condition: redirect = exc | jump | (branch==01 & alu_zero) | (branch==10 & !alu_zero).
REQ-020 Redirect target priority: exc -> EXC_VECTOR; else jump -> jump_target; else branch_target.
REQ-021 All targets have bits [1:0] forced to 00 before use; pc_cur[1:0] is always 00.
REQ-022 The FSM has states ISSUE, WAIT, HOLD and DISCARD.
REQ-023 ISSUE: imem_req = !stall and imem_addr = pc_cur.
 - req with no ack -> WAIT.
 - req with ack in the same cycle -> completion (REQ-025).
REQ-024 WAIT: imem_req = 1 and imem_addr = pc_cur, held stable until ack.
 - stall does not withdraw the request.
 - on ack -> completion (REQ-025).
REQ-025 Completion with no redirect and no pending redirect, at the ack edge:
 - fetch_valid <= 1 and fetch_pc <= pc_cur.
 - pc_cur <= pc_cur + 4, 32-bit wrap: 32'hFFFFFFFC -> 0.
 - stall = 1 -> HOLD; else -> ISSUE.
REQ-026 fetch_valid is high for exactly one cycle per completion unless held in HOLD.
REQ-027 HOLD: imem_req = 0; fetch_valid and fetch_pc are held; exit to ISSUE on the first edge with stall = 0.
REQ-028 Redirect with no outstanding request (ISSUE or HOLD), at that edge:
 - pc_cur <= target and fetch_valid <= 0.
 - flush_ifid <= 1 for one cycle.
 - next state ISSUE.
 - no request is issued in that cycle (imem_req is forced 0).
REQ-029 Redirect in WAIT without ack: latch the target into a pending register, pulse flush_ifid, go to DISCARD.
REQ-030 Redirect in WAIT coinciding with ack: the returned instruction is dropped (fetch_valid <= 0), pc_cur <= target, flush_ifid pulses, next state ISSUE.
REQ-031 DISCARD: imem_req = 1 at the old address until ack.
 - a further redirect overwrites the pending target (latest wins) and pulses flush_ifid again.
 - on ack: the data is dropped, pc_cur <= pending target (or the same-cycle redirect target), next state ISSUE.
REQ-032 Redirect has priority over stall in every state.
REQ-033 An ack in ISSUE with imem_req = 0, or an ack in HOLD, is ignored.

Reset
REQ-034 While rst is high, the block holds its reset values, with no clock required:
 - state ISSUE.
 - pc_cur = RESET_PC.
 - fetch_pc = RESET_PC.
 - fetch_valid = 0, flush_ifid = 0.
 - pending cleared.
 - imem_req = 0.
REQ-035 Reset asserted mid-transaction abandons the transaction; the first request after reset release is to RESET_PC.

Verification
REQ-036 Reset release, stall = 0, ack tied high -> requests to 3000, 3004, 3008 on consecutive cycles; fetch_valid high with the matching fetch_pc.
REQ-037 Ack delayed 3 cycles with stall = 1 from the request cycle -> imem_addr is held at 3000; completion goes to HOLD; fetch_valid/fetch_pc = 3000 are held until stall drops.
REQ-038 beq with alu_zero = 1 and branch_target 32'h00003043 while in ISSUE -> pc_cur = 3040; flush_ifid pulses one cycle; the next request is to 3040.
REQ-039 jump to 5000 during WAIT, then exc before ack -> DISCARD; flush_ifid pulses twice; the late ack data is dropped; the next request is to 4180.
REQ-040 pc_cur = FFFFFFFC and its fetch completes -> pc_cur = 00000000.
REQ-041 rst asserted during WAIT -> imem_req = 0 immediately; after release, the request is to 3000.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer and its neighbours:
// control-flow inputs, the instruction-memory handshake and the IF/ID outputs.
interface pc_sequencer_if;
   logic        stall;
   logic        exc;
   logic        jump;
   logic [31:0] jump_target;
   logic [1:0]  branch;
   logic        alu_zero;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        flush_ifid;
   logic [31:0] pc_cur;

   modport master (
      output stall, exc, jump, jump_target, branch, alu_zero, branch_target, imem_ack,
      input  imem_req, imem_addr, fetch_valid, fetch_pc, flush_ifid, pc_cur
   );

   modport slave (
      input  stall, exc, jump, jump_target, branch, alu_zero, branch_target, imem_ack,
      output imem_req, imem_addr, fetch_valid, fetch_pc, flush_ifid, pc_cur
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues word-aligned fetches, tracks the single
// outstanding request and applies exception/jump/branch redirects.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
   input  logic           clk,
   input  logic           rst,
   pc_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DISCARD} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] pend_q, pend_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic        flush_q, flush_d;

   logic        redirect;
   logic [31:0] raw_target;
   logic [31:0] target;
   logic        complete;
   logic        req_c;

   always_comb begin
      redirect = bus.exc | bus.jump |
                 ((bus.branch == 2'b01) &  bus.alu_zero) |
                 ((bus.branch == 2'b10) & ~bus.alu_zero);
      if (bus.exc)       raw_target = EXC_VECTOR;
      else if (bus.jump) raw_target = bus.jump_target;
      else               raw_target = bus.branch_target;
      target = raw_target & ~32'd3;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ISSUE;
         pc_q          <= RESET_PC & ~32'd3;
         fetch_pc_q    <= RESET_PC & ~32'd3;
         pend_q        <= '0;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_pc_q    <= fetch_pc_d;
         pend_q        <= pend_d;
         fetch_valid_q <= fetch_valid_d;
         flush_q       <= flush_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_pc_d    = fetch_pc_q;
      pend_d        = pend_q;
      fetch_valid_d = 1'b0;
      flush_d       = redirect;
      complete      = 1'b0;
      req_c         = 1'b0;

      case (state_q)
         ISSUE: begin
            // A redirect cycle never issues: the address it would use is stale.
            req_c = ~bus.stall & ~redirect;
            if (redirect) begin
               pc_d = target;
            end else if (!bus.stall) begin
               if (bus.imem_ack) complete = 1'b1;
               else              state_d  = WAIT;
            end
         end
         WAIT: begin
            req_c = 1'b1;
            if (redirect) begin
               if (bus.imem_ack) begin
                  pc_d    = target;
                  state_d = ISSUE;
               end else begin
                  pend_d  = target;
                  state_d = DISCARD;
               end
            end else if (bus.imem_ack) begin
               complete = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = ISSUE;
            end else if (!bus.stall) begin
               state_d = ISSUE;
            end else begin
               fetch_valid_d = fetch_valid_q;
            end
         end
         DISCARD: begin
            // Keep the old request up until memory answers; the data is thrown away.
            req_c = 1'b1;
            if (bus.imem_ack) begin
               pc_d    = redirect ? target : pend_q;
               state_d = ISSUE;
            end else if (redirect) begin
               pend_d = target;
            end
         end
         default: state_d = ISSUE;
      endcase

      if (complete) begin
         fetch_valid_d = 1'b1;
         fetch_pc_d    = pc_q;
         pc_d          = pc_q + 32'd4;
         state_d       = bus.stall ? HOLD : ISSUE;
      end
   end

   assign bus.imem_req    = req_c & ~rst;
   assign bus.imem_addr   = pc_q;
   assign bus.pc_cur      = pc_q;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_pc    = fetch_pc_q;
   assign bus.flush_ifid  = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed fetch/redirect scenarios followed by random traffic, all checked
// every cycle against a transaction-level model of the sequencer.
module tb_pc_sequencer;
   localparam logic [31:0] RPC = 32'h0000_3000;
   localparam logic [31:0] EXV = 32'h0000_4180;

   logic clk = 1'b0;
   logic rst;

   pc_sequencer_if bus();

   pc_sequencer #(.RESET_PC(RPC), .EXC_VECTOR(EXV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: a fetch is either in flight or not, may be doomed, and the
   // fetched word may be parked while the pipe is stalled.
   logic [31:0] m_pc, m_fpc, m_pend;
   logic        m_fv, m_flush, m_out, m_drop, m_hold;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic m_redir();
      return bus.exc | bus.jump | ((bus.branch == 2'b01) & bus.alu_zero) |
             ((bus.branch == 2'b10) & !bus.alu_zero);
   endfunction

   function automatic logic [31:0] m_tgt();
      logic [31:0] t;
      t = bus.exc ? EXV : (bus.jump ? bus.jump_target : bus.branch_target);
      return {t[31:2], 2'b00};
   endfunction

   task automatic m_reset();
      m_pc = RPC; m_fpc = RPC; m_pend = '0;
      m_fv = 1'b0; m_flush = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_hold = 1'b0;
   endtask

   task automatic m_edge();
      logic        r, done;
      logic [31:0] t;
      r = m_redir(); t = m_tgt(); done = 1'b0;
      m_flush = r;
      if (m_out) begin
         if (bus.imem_ack) begin
            if (!m_drop && !r) done = 1'b1;
            else begin m_pc = r ? t : m_pend; m_fv = 1'b0; end
            m_out = 1'b0; m_drop = 1'b0;
         end else if (r) begin
            m_pend = t; m_drop = 1'b1; m_fv = 1'b0;
         end
      end else if (r) begin
         m_pc = t; m_fv = 1'b0; m_hold = 1'b0;
      end else if (m_hold) begin
         if (!bus.stall) begin m_hold = 1'b0; m_fv = 1'b0; end
      end else begin
         m_fv = 1'b0;
         if (!bus.stall) begin
            if (bus.imem_ack) done = 1'b1;
            else              m_out = 1'b1;
         end
      end
      if (done) begin
         m_fv = 1'b1; m_fpc = m_pc; m_pc = m_pc + 32'd4;
         m_hold = bus.stall; m_out = 1'b0;
      end
   endtask

   task automatic check_all();
      logic exp_req;
      exp_req = !rst && (m_out || (!m_hold && !bus.stall && !m_redir()));
      chk("imem_req",    {31'b0, bus.imem_req},    {31'b0, exp_req});
      chk("imem_addr",   bus.imem_addr,            m_pc);
      chk("pc_cur",      bus.pc_cur,               m_pc);
      chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, m_fv});
      chk("fetch_pc",    bus.fetch_pc,             m_fpc);
      chk("flush_ifid",  {31'b0, bus.flush_ifid},  {31'b0, m_flush});
   endtask

   task automatic cycle();
      @(negedge clk);
      check_all();
      @(posedge clk);
      if (rst) m_reset();
      else     m_edge();
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall = 1'b0; bus.exc = 1'b0; bus.jump = 1'b0; bus.jump_target = '0;
      bus.branch = 2'b00; bus.alu_zero = 1'b0; bus.branch_target = '0; bus.imem_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_reset();
      #2;
      check_all();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      m_reset();
      #2;
      // Reset values with no clock edge yet.
      chk("rst_pc_cur",   bus.pc_cur, RPC);
      chk("rst_fetch_pc", bus.fetch_pc, RPC);
      chk("rst_req",      {31'b0, bus.imem_req}, 32'd0);
      chk("rst_fv",       {31'b0, bus.fetch_valid}, 32'd0);
      chk("rst_flush",    {31'b0, bus.flush_ifid}, 32'd0);
      cycle();
      rst = 1'b0;

      // Back-to-back fetches with ack tied high.
      bus.imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("b2b_fv",   {31'b0, bus.fetch_valid}, 32'd1);
         chk("b2b_fpc",  bus.fetch_pc, RPC + 32'(4 * i));
         chk("b2b_addr", bus.imem_addr, RPC + 32'(4 * (i + 1)));
      end

      // Slow ack under stall: address held, completion parks in HOLD.
      idle_inputs();
      do_reset();
      cycle();
      bus.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("wait_addr", bus.imem_addr, RPC);
         chk("wait_req",  {31'b0, bus.imem_req}, 32'd1);
      end
      bus.imem_ack = 1'b1;
      cycle();
      bus.imem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("hold_fv",  {31'b0, bus.fetch_valid}, 32'd1);
         chk("hold_fpc", bus.fetch_pc, RPC);
         chk("hold_req", {31'b0, bus.imem_req}, 32'd0);
      end
      bus.stall = 1'b0;
      cycle();
      chk("hold_exit_fv", {31'b0, bus.fetch_valid}, 32'd0);

      // Taken beq in ISSUE with a misaligned target.
      bus.branch = 2'b01; bus.alu_zero = 1'b1; bus.branch_target = 32'h0000_3043;
      cycle();
      chk("beq_pc",    bus.pc_cur, 32'h0000_3040);
      chk("beq_flush", {31'b0, bus.flush_ifid}, 32'd1);
      idle_inputs();
      cycle();
      chk("beq_flush_off", {31'b0, bus.flush_ifid}, 32'd0);
      chk("beq_addr",      bus.imem_addr, 32'h0000_3040);

      // Jump then exception while the fetch is outstanding.
      bus.jump = 1'b1; bus.jump_target = 32'h0000_5000;
      cycle();
      chk("disc_flush1", {31'b0, bus.flush_ifid}, 32'd1);
      bus.jump = 1'b0; bus.exc = 1'b1;
      cycle();
      chk("disc_flush2", {31'b0, bus.flush_ifid}, 32'd1);
      chk("disc_addr",   bus.imem_addr, 32'h0000_3040);
      bus.exc = 1'b0;
      cycle();
      bus.imem_ack = 1'b1;
      cycle();
      bus.imem_ack = 1'b0;
      chk("disc_fv",   {31'b0, bus.fetch_valid}, 32'd0);
      chk("disc_addr", bus.imem_addr, EXV);
      chk("disc_req",  {31'b0, bus.imem_req}, 32'd1);

      // PC wrap at the top of the address space.
      bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFF;
      cycle();
      chk("wrap_pre", bus.pc_cur, 32'hFFFF_FFFC);
      bus.jump = 1'b0; bus.imem_ack = 1'b1;
      cycle();
      bus.imem_ack = 1'b0;
      chk("wrap_pc",  bus.pc_cur, 32'h0000_0000);
      chk("wrap_fpc", bus.fetch_pc, 32'hFFFF_FFFC);

      // Reset in the middle of an outstanding fetch.
      cycle();
      rst = 1'b1;
      m_reset();
      #1;
      chk("rst_wait_req", {31'b0, bus.imem_req}, 32'd0);
      chk("rst_wait_pc",  bus.pc_cur, RPC);
      cycle();
      rst = 1'b0;
      cycle();
      chk("rst_wait_addr", bus.imem_addr, RPC);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         rst              = ($urandom_range(199) == 0);
         if (rst) m_reset();
         bus.stall        = ($urandom_range(9) < 3);
         bus.imem_ack     = ($urandom_range(9) < 4);
         bus.exc          = ($urandom_range(39) == 0);
         bus.jump         = ($urandom_range(19) == 0);
         bus.jump_target  = $urandom;
         bus.branch       = ($urandom_range(4) == 0) ? 2'($urandom) : 2'b00;
         bus.alu_zero     = 1'($urandom);
         bus.branch_target = $urandom;
         cycle();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
